rv_multicycle_ctrl: RTL and testbench
=====================================

Name: rv_multicycle_ctrl

Overview:
Parametrised multi-cycle sequencer for the RV32I core. It replaces the free-running single-cycle flow with an explicit FETCH/DECODE/EXECUTE/MEM/WB state machine. It owns the PC, latches the instruction, and handshakes with variable-latency instruction and data memories. It also gates register-file writeback, counts retired instructions, and traps on bus faults, timeouts, illegal opcodes and misaligned targets.

Parameters:
XLEN, 32, PC and next-PC width.
RESET_PC, 32'h0000_0000, PC value loaded on reset.
TIMEOUT, 15, maximum wait cycles on one memory request before a fault; the valid range is 1..255.
CNT_W, 32, retire counter width.

Ports:
clk_i  in  1  clock, rising edge
rst_n_i  in  1  reset, asynchronous, active-low
imem_req_o  out  1  instruction fetch request, held until it completes
imem_addr_o  out  XLEN  fetch address, always equal to the current PC
imem_rdata_i  in  32  fetched instruction word
imem_valid_i  in  1  fetch data valid
imem_err_i  in  1  fetch bus error
instr_o  out  32  latched instruction, drives the fetch/decode datapath
opcode_i  in  7  decoded opcode of instr_o
ex_en_o  out  1  one-cycle execute/condition-code strobe
cnd_i  in  1  branch condition from the execute stage
next_pc_i  in  XLEN  next PC from the PC-select logic
dmem_req_o  out  1  data request, held until it completes
dmem_we_o  out  1  1 = store, 0 = load; valid only while dmem_req_o is high
dmem_valid_i  in  1  data access complete
dmem_err_i  in  1  data bus error
rf_we_o  out  1  one-cycle register-file write enable
pc_o  out  XLEN  current PC
state_o  out  3  encoded FSM state, for debug
halted_o  out  1  core stopped (halt or trap)
trap_cause_o  out  2  0 none, 1 imem fault, 2 dmem fault, 3 illegal opcode or misaligned PC
retire_cnt_o  out  CNT_W  retired instruction count

Behaviour:
- Reset (rst_n_i low, asynchronous):
  - pc_o = RESET_PC, instr_o = 0, state = FETCH, retire_cnt_o = 0, trap_cause_o = 0.
  - imem_req_o, dmem_req_o, dmem_we_o, ex_en_o, rf_we_o and halted_o are all 0.
  - Requests drop immediately, even mid-transaction.
  - The first imem_req_o is asserted in the first cycle after release.
- State encoding: FETCH=0, DECODE=1, EXECUTE=2, MEM=3, WB=4, HALT=5, TRAP=6.
- Wait counter:
  - Cleared on entry to FETCH and to MEM.
  - Increments every cycle a request is outstanding.
  - When it reaches TIMEOUT with no valid or err, the state moves to TRAP with cause 1 (FETCH) or 2 (MEM).
- FETCH:
  - imem_req_o = 1.
  - If imem_err_i: go to TRAP, cause 1.
  - Else if imem_valid_i: latch instr_o <= imem_rdata_i and go to DECODE.
  - Error wins when valid and error arrive in the same cycle.
- DECODE (1 cycle):
  - Legal opcodes: 0110111 LUI, 0010111 AUIPC, 1101111 JAL, 1100111 JALR, 1100011 BRANCH, 0000011 LOAD, 0100011 STORE, 0010011 IMM, 0110011 R, 1110011 SYSTEM.
  - Any other opcode, or instr_o[1:0] != 2'b11: go to TRAP, cause 3.
  - SYSTEM: go to HALT with no retire and no PC update.
  - Otherwise go to EXECUTE.
- EXECUTE (1 cycle):
  - ex_en_o = 1.
  - LOAD or STORE goes to MEM; everything else goes to WB.
- MEM:
  - dmem_req_o = 1; dmem_we_o = 1 for STORE.
  - dmem_err_i goes to TRAP, cause 2; otherwise dmem_valid_i goes to WB. Error wins.
- WB (1 cycle):
  - rf_we_o = 1 for LUI, AUIPC, JAL, JALR, IMM, R, LOAD; 0 for BRANCH, STORE.
  - If next_pc_i[1:0] != 0: go to TRAP, cause 3, with no PC update and no retire.
  - Otherwise pc_o <= next_pc_i, retire_cnt_o increments (wraps at 2^CNT_W), and the state returns to FETCH.
- cnd_i is monitored only, for branches; the PC-select logic has already folded it into next_pc_i.
- Cycles per instruction: 4 + fetch wait for non-memory instructions; 5 + fetch wait + data wait for LOAD/STORE. A zero-wait fetch means imem_valid_i is asserted in the first FETCH cycle.
- HALT and TRAP:
  - halted_o = 1 and all strobes and requests are 0.
  - pc_o holds the faulting or halting instruction's PC; instr_o holds its value.
  - trap_cause_o holds until reset; it stays 0 in HALT.
  - The only exit is reset.
- Late responses: valid or err arriving when no request is outstanding is ignored.

Test Plan:
1. Zero-wait ADDI at PC 0 (imem_valid_i the same cycle as the request), next_pc_i=4 -> rf_we_o pulses in cycle 4, pc_o=4, retire_cnt_o=1, and the next imem_req_o is in cycle 5.
2. LW with 3-cycle imem and 2-cycle dmem latency -> dmem_req_o=1 with dmem_we_o=0 for 2 cycles, rf_we_o once, retire_cnt_o increments; SW of the same shape -> dmem_we_o=1 and rf_we_o stays 0.
3. BEQ with cnd_i=1, next_pc_i=0x40 -> rf_we_o stays 0, pc_o=0x40; then opcode 1110011 -> halted_o=1, trap_cause_o=0, pc_o=0x40 and retire count unchanged.
4. imem_valid_i never asserted with TIMEOUT=15 -> TRAP after 15 wait cycles, trap_cause_o=1, imem_req_o=0; imem_err_i and imem_valid_i together on a second run -> cause 1 as well.
5. Opcode 0000000, and separately JALR with next_pc_i=0x102 -> TRAP with cause 3 in both cases; pc_o is unchanged.
6. rst_n_i low during MEM with dmem_req_o=1 -> dmem_req_o drops with no clock edge; after release pc_o=RESET_PC, retire_cnt_o=0 and FETCH restarts.

Source files
------------

// File: rtl/rv_multicycle_ctrl.sv
// Multi-cycle FETCH/DECODE/EXECUTE/MEM/WB sequencer for the RV32I core.
// Owns the PC and instruction latch, handshakes with variable-latency
// instruction/data memories, gates writeback and traps on faults.
module rv_multicycle_ctrl #(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  // Wait cycles allowed per memory request; meaningful range is 1..255
  parameter int unsigned     TIMEOUT  = 15,
  parameter int unsigned     CNT_W    = 32
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  output logic             imem_req_o,
  output logic [XLEN-1:0]  imem_addr_o,
  input  logic [31:0]      imem_rdata_i,
  input  logic             imem_valid_i,
  input  logic             imem_err_i,
  output logic [31:0]      instr_o,
  input  logic [6:0]       opcode_i,
  output logic             ex_en_o,
  input  logic             cnd_i,
  input  logic [XLEN-1:0]  next_pc_i,
  output logic             dmem_req_o,
  output logic             dmem_we_o,
  input  logic             dmem_valid_i,
  input  logic             dmem_err_i,
  output logic             rf_we_o,
  output logic [XLEN-1:0]  pc_o,
  output logic [2:0]       state_o,
  output logic             halted_o,
  output logic [1:0]       trap_cause_o,
  output logic [CNT_W-1:0] retire_cnt_o
);

  typedef enum logic [2:0] {
    StFetch   = 3'd0,
    StDecode  = 3'd1,
    StExecute = 3'd2,
    StMem     = 3'd3,
    StWb      = 3'd4,
    StHalt    = 3'd5,
    StTrap    = 3'd6
  } state_e;

  localparam logic [6:0] OpLui    = 7'b0110111;
  localparam logic [6:0] OpAuipc  = 7'b0010111;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpImm    = 7'b0010011;
  localparam logic [6:0] OpReg    = 7'b0110011;
  localparam logic [6:0] OpSystem = 7'b1110011;

  localparam logic [1:0] CauseNone    = 2'd0;
  localparam logic [1:0] CauseImem    = 2'd1;
  localparam logic [1:0] CauseDmem    = 2'd2;
  localparam logic [1:0] CauseIllegal = 2'd3;

  localparam logic [7:0] TimeoutCnt = 8'(TIMEOUT);

  state_e           state_q;
  logic [XLEN-1:0]  pc_q;
  logic [31:0]      instr_q;
  logic [7:0]       wait_q;
  logic [CNT_W-1:0] retire_q;
  logic [1:0]       cause_q;
  logic             imem_req_q;
  logic             dmem_req_q;
  logic             dmem_we_q;
  logic             ex_en_q;
  logic             rf_we_q;
  logic             halted_q;

  logic             op_legal;
  logic             op_mem;
  logic             op_store;
  logic             op_system;
  logic             op_wr_rd;
  logic [7:0]       wait_inc;
  logic             timed_out;

  // The branch condition is already folded into next_pc_i by the PC-select logic.
  logic unused_cnd;
  assign unused_cnd = cnd_i;

  // Opcode classification for the latched instruction.
  always_comb begin
    op_legal  = 1'b1;
    op_mem    = 1'b0;
    op_store  = 1'b0;
    op_system = 1'b0;
    op_wr_rd  = 1'b0;
    case (opcode_i)
      OpLui, OpAuipc, OpJal, OpJalr, OpImm, OpReg: op_wr_rd = 1'b1;
      OpLoad: begin
        op_mem   = 1'b1;
        op_wr_rd = 1'b1;
      end
      OpStore: begin
        op_mem   = 1'b1;
        op_store = 1'b1;
      end
      OpBranch: op_wr_rd = 1'b0;
      OpSystem: op_system = 1'b1;
      default:  op_legal = 1'b0;
    endcase
  end

  // Wait-counter step and timeout detection for the outstanding request.
  always_comb begin
    wait_inc  = wait_q + 8'd1;
    timed_out = (wait_inc == TimeoutCnt);
  end

  // Sequencer: state, PC, instruction latch, counters and registered outputs.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q    <= StFetch;
      pc_q       <= RESET_PC;
      instr_q    <= '0;
      wait_q     <= '0;
      retire_q   <= '0;
      cause_q    <= CauseNone;
      imem_req_q <= 1'b0;
      dmem_req_q <= 1'b0;
      dmem_we_q  <= 1'b0;
      ex_en_q    <= 1'b0;
      rf_we_q    <= 1'b0;
      halted_q   <= 1'b0;
    end else begin
      ex_en_q <= 1'b0;
      rf_we_q <= 1'b0;
      case (state_q)
        StFetch: begin
          if (!imem_req_q) begin
            // Only reachable straight out of reset: raise the first request.
            imem_req_q <= 1'b1;
            wait_q     <= '0;
          end else if (imem_err_i || (!imem_valid_i && timed_out)) begin
            imem_req_q <= 1'b0;
            halted_q   <= 1'b1;
            cause_q    <= CauseImem;
            state_q    <= StTrap;
          end else if (imem_valid_i) begin
            imem_req_q <= 1'b0;
            instr_q    <= imem_rdata_i;
            state_q    <= StDecode;
          end else begin
            wait_q <= wait_inc;
          end
        end
        StDecode: begin
          if (!op_legal || (instr_q[1:0] != 2'b11)) begin
            halted_q <= 1'b1;
            cause_q  <= CauseIllegal;
            state_q  <= StTrap;
          end else if (op_system) begin
            halted_q <= 1'b1;
            state_q  <= StHalt;
          end else begin
            ex_en_q <= 1'b1;
            state_q <= StExecute;
          end
        end
        StExecute: begin
          if (op_mem) begin
            dmem_req_q <= 1'b1;
            dmem_we_q  <= op_store;
            wait_q     <= '0;
            state_q    <= StMem;
          end else begin
            rf_we_q <= op_wr_rd;
            state_q <= StWb;
          end
        end
        StMem: begin
          if (dmem_err_i || (!dmem_valid_i && timed_out)) begin
            dmem_req_q <= 1'b0;
            dmem_we_q  <= 1'b0;
            halted_q   <= 1'b1;
            cause_q    <= CauseDmem;
            state_q    <= StTrap;
          end else if (dmem_valid_i) begin
            dmem_req_q <= 1'b0;
            dmem_we_q  <= 1'b0;
            rf_we_q    <= op_wr_rd;
            state_q    <= StWb;
          end else begin
            wait_q <= wait_inc;
          end
        end
        StWb: begin
          if (next_pc_i[1:0] != 2'b00) begin
            // Misaligned target: keep the PC of the offending instruction.
            halted_q <= 1'b1;
            cause_q  <= CauseIllegal;
            state_q  <= StTrap;
          end else begin
            pc_q       <= next_pc_i;
            retire_q   <= retire_q + CNT_W'(1);
            imem_req_q <= 1'b1;
            wait_q     <= '0;
            state_q    <= StFetch;
          end
        end
        StHalt, StTrap: begin
          state_q <= state_q;
        end
        default: begin
          imem_req_q <= 1'b0;
          dmem_req_q <= 1'b0;
          dmem_we_q  <= 1'b0;
          halted_q   <= 1'b1;
          cause_q    <= CauseIllegal;
          state_q    <= StTrap;
        end
      endcase
    end
  end

  assign imem_req_o   = imem_req_q;
  assign imem_addr_o  = pc_q;
  assign instr_o      = instr_q;
  assign ex_en_o      = ex_en_q;
  assign dmem_req_o   = dmem_req_q;
  assign dmem_we_o    = dmem_we_q;
  assign rf_we_o      = rf_we_q;
  assign pc_o         = pc_q;
  assign state_o      = state_q;
  assign halted_o     = halted_q;
  assign trap_cause_o = cause_q;
  assign retire_cnt_o = retire_q;

endmodule

// File: tb/tb_rv_multicycle_ctrl.sv
// Scoreboard bench for rv_multicycle_ctrl: stimulus pushes the expected
// outcome of each instruction; a monitor pops it when the instruction closes
// (next fetch request rises, or the core stops).
module tb_rv_multicycle_ctrl;

  logic        clk_i;
  logic        rst_n_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic [31:0] imem_rdata_i;
  logic        imem_valid_i;
  logic        imem_err_i;
  logic [31:0] instr_o;
  logic [6:0]  opcode_i;
  logic        ex_en_o;
  logic        cnd_i;
  logic [31:0] next_pc_i;
  logic        dmem_req_o;
  logic        dmem_we_o;
  logic        dmem_valid_i;
  logic        dmem_err_i;
  logic        rf_we_o;
  logic [31:0] pc_o;
  logic [2:0]  state_o;
  logic        halted_o;
  logic [1:0]  trap_cause_o;
  logic [31:0] retire_cnt_o;

  rv_multicycle_ctrl #(
    .XLEN     (32),
    .RESET_PC (32'h0000_0000),
    .TIMEOUT  (15),
    .CNT_W    (32)
  ) dut (
    .clk_i        (clk_i),
    .rst_n_i      (rst_n_i),
    .imem_req_o   (imem_req_o),
    .imem_addr_o  (imem_addr_o),
    .imem_rdata_i (imem_rdata_i),
    .imem_valid_i (imem_valid_i),
    .imem_err_i   (imem_err_i),
    .instr_o      (instr_o),
    .opcode_i     (opcode_i),
    .ex_en_o      (ex_en_o),
    .cnd_i        (cnd_i),
    .next_pc_i    (next_pc_i),
    .dmem_req_o   (dmem_req_o),
    .dmem_we_o    (dmem_we_o),
    .dmem_valid_i (dmem_valid_i),
    .dmem_err_i   (dmem_err_i),
    .rf_we_o      (rf_we_o),
    .pc_o         (pc_o),
    .state_o      (state_o),
    .halted_o     (halted_o),
    .trap_cause_o (trap_cause_o),
    .retire_cnt_o (retire_cnt_o)
  );

  assign opcode_i = instr_o[6:0];

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  localparam logic [31:0] IAddi  = 32'h0010_0093;
  localparam logic [31:0] ILw    = 32'h0040_2103;
  localparam logic [31:0] ISw    = 32'h0020_2423;
  localparam logic [31:0] IBeq   = 32'h0000_0063;
  localparam logic [31:0] IEbrk  = 32'h0010_0073;
  localparam logic [31:0] IJalr  = 32'h0000_80e7;
  localparam logic [31:0] IZero  = 32'h0000_0000;

  typedef struct {
    logic        stop;
    logic [2:0]  st;
    logic [1:0]  cause;
    logic [31:0] pc;
    logic [31:0] ret;
    logic        instr_v;
    logic [31:0] instr;
    int          rf;
    int          ex;
    int          dm;
    int          dwe;
    int          im;
    int          cyc;
  } exp_t;

  exp_t exp_q[$];
  int   vectors;
  int   miscompares;
  int   s_rf, s_ex, s_dm, s_dwe, s_im, s_cyc;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, req, $time);
    end
  endtask

  task automatic exp_fetch(input logic [31:0] pc, input logic [31:0] ret, input int rf,
                           input int ex, input int dm, input int dwe, input int im,
                           input int cyc);
    exp_t e;
    e.stop = 1'b0; e.st = 3'd0; e.cause = 2'd0; e.pc = pc; e.ret = ret;
    e.instr_v = 1'b0; e.instr = '0;
    e.rf = rf; e.ex = ex; e.dm = dm; e.dwe = dwe; e.im = im; e.cyc = cyc;
    exp_q.push_back(e);
  endtask

  task automatic exp_start();
    exp_fetch(32'h0, 32'h0, -1, -1, -1, -1, -1, -1);
  endtask

  task automatic exp_stop(input logic [2:0] st, input logic [1:0] cause, input logic [31:0] pc,
                          input logic [31:0] ret, input logic [31:0] instr, input int rf,
                          input int ex, input int im, input int cyc);
    exp_t e;
    e.stop = 1'b1; e.st = st; e.cause = cause; e.pc = pc; e.ret = ret;
    e.instr_v = 1'b1; e.instr = instr;
    e.rf = rf; e.ex = ex; e.dm = 0; e.dwe = 0; e.im = im; e.cyc = cyc;
    exp_q.push_back(e);
  endtask

  // Monitor: closes an instruction window on a fetch-request rise or a stop.
  initial begin
    exp_t e;
    logic prev_req, prev_halt, ev;
    prev_req = 1'b0; prev_halt = 1'b0;
    s_rf = 0; s_ex = 0; s_dm = 0; s_dwe = 0; s_im = 0; s_cyc = 0;
    forever begin
      @(negedge clk_i);
      if (!rst_n_i) begin
        prev_req = 1'b0; prev_halt = 1'b0;
        s_rf = 0; s_ex = 0; s_dm = 0; s_dwe = 0; s_im = 0; s_cyc = 0;
      end else begin
        ev = (imem_req_o && !prev_req) || (halted_o && !prev_halt);
        if (ev) begin
          if (exp_q.size() == 0) begin
            vectors++; miscompares++;
            $display("FAIL unexpected_event: state %0d pc 0x%0h, expected no event", state_o, pc_o);
          end else begin
            e = exp_q.pop_front();
            chk("event_kind", {31'd0, halted_o}, {31'd0, e.stop});
            chk("state", {29'd0, state_o}, {29'd0, e.st});
            chk("trap_cause", {30'd0, trap_cause_o}, {30'd0, e.cause});
            chk("pc", pc_o, e.pc);
            chk("imem_addr", imem_addr_o, e.pc);
            chk("retire_cnt", retire_cnt_o, e.ret);
            chk("strobes", {28'd0, imem_req_o, dmem_req_o, ex_en_o, rf_we_o},
                e.stop ? 32'h0 : 32'h8);
            if (e.instr_v) chk("instr", instr_o, e.instr);
            if (e.rf >= 0)  chk("rf_we_pulses", s_rf, e.rf);
            if (e.ex >= 0)  chk("ex_en_pulses", s_ex, e.ex);
            if (e.dm >= 0)  chk("dmem_req_cycles", s_dm, e.dm);
            if (e.dwe >= 0) chk("dmem_we_cycles", s_dwe, e.dwe);
            if (e.im >= 0)  chk("imem_req_cycles", s_im, e.im);
            if (e.cyc >= 0) chk("instr_cycles", s_cyc, e.cyc);
          end
          s_rf = 0; s_ex = 0; s_dm = 0; s_dwe = 0; s_im = 0; s_cyc = 0;
        end
        s_cyc++;
        s_rf  += int'(rf_we_o);
        s_ex  += int'(ex_en_o);
        s_dm  += int'(dmem_req_o);
        s_dwe += int'(dmem_req_o && dmem_we_o);
        s_im  += int'(imem_req_o);
        prev_req  = imem_req_o;
        prev_halt = halted_o;
      end
    end
  end

  // Drops reset between clock edges and checks that everything clears at once.
  task automatic do_reset(input bit align);
    if (align) @(negedge clk_i);
    #2;
    rst_n_i = 1'b0;
    #1;
    chk("rst_imem_req", {31'd0, imem_req_o}, 32'd0);
    chk("rst_dmem_req", {31'd0, dmem_req_o}, 32'd0);
    chk("rst_halted", {31'd0, halted_o}, 32'd0);
    chk("rst_cause", {30'd0, trap_cause_o}, 32'd0);
    chk("rst_pc", pc_o, 32'h0);
    chk("rst_retire", retire_cnt_o, 32'd0);
    chk("rst_state", {29'd0, state_o}, 32'd0);
    chk("rst_instr", instr_o, 32'h0);
    imem_valid_i = 1'b0; imem_err_i = 1'b0; dmem_valid_i = 1'b0; dmem_err_i = 1'b0;
    @(negedge clk_i);
    @(negedge clk_i);
  endtask

  task automatic release_rst();
    #1 rst_n_i = 1'b1;
  endtask

  // Memory model for one instruction: iwait/dwait extra cycles, negative = never respond.
  task automatic serve(input logic [31:0] ins, input int iwait, input int dwait,
                       input logic [31:0] npc, input logic ierr, input logic cnd);
    int n;
    logic [6:0] op;
    n = 0;
    while (!imem_req_o && n < 50) begin
      @(negedge clk_i);
      n++;
    end
    if (!imem_req_o) begin
      vectors++; miscompares++;
      $display("FAIL fetch_req_wait: imem_req_o=0 after %0d cycles, expected 1", n);
      return;
    end
    if (iwait < 0) return;
    repeat (iwait) @(negedge clk_i);
    imem_rdata_i = ins; imem_valid_i = 1'b1; imem_err_i = ierr;
    next_pc_i = npc; cnd_i = cnd;
    @(negedge clk_i);
    imem_valid_i = 1'b0; imem_err_i = 1'b0;
    op = ins[6:0];
    if (!ierr && (op == 7'b0000011 || op == 7'b0100011)) begin
      n = 0;
      while (!dmem_req_o && n < 10) begin
        @(negedge clk_i);
        n++;
      end
      if (!dmem_req_o) begin
        vectors++; miscompares++;
        $display("FAIL dmem_req_wait: dmem_req_o=0 after %0d cycles, expected 1", n);
        return;
      end
      if (dwait < 0) return;
      repeat (dwait) @(negedge clk_i);
      dmem_valid_i = 1'b1;
      @(negedge clk_i);
      dmem_valid_i = 1'b0;
    end
  endtask

  task automatic wait_stop(input int limit);
    int n;
    n = 0;
    while (!halted_o && n < limit) begin
      @(negedge clk_i);
      n++;
    end
    chk("stop_reached", {31'd0, halted_o}, 32'd1);
  endtask

  // Late responses while stopped must be ignored; the core stays put.
  task automatic idle_check(input logic [2:0] st);
    @(negedge clk_i);
    imem_valid_i = 1'b1; imem_err_i = 1'b1; dmem_valid_i = 1'b1; dmem_err_i = 1'b1;
    @(negedge clk_i);
    imem_valid_i = 1'b0; imem_err_i = 1'b0; dmem_valid_i = 1'b0; dmem_err_i = 1'b0;
    repeat (3) @(negedge clk_i);
    chk("queue_drained", exp_q.size(), 32'd0);
    chk("stop_hold_halted", {31'd0, halted_o}, 32'd1);
    chk("stop_hold_state", {29'd0, state_o}, {29'd0, st});
    chk("stop_hold_imem_req", {31'd0, imem_req_o}, 32'd0);
  endtask

  initial begin
    int n;
    vectors = 0; miscompares = 0;
    rst_n_i = 1'b1;
    imem_rdata_i = '0; imem_valid_i = 1'b0; imem_err_i = 1'b0;
    dmem_valid_i = 1'b0; dmem_err_i = 1'b0; cnd_i = 1'b0; next_pc_i = '0;

    // ADDI, LW, SW, BEQ then EBREAK halt.
    do_reset(1'b0);
    exp_start();
    release_rst();
    exp_fetch(32'h4, 32'd1, 1, 1, 0, 0, 1, 4);
    serve(IAddi, 0, 0, 32'h4, 1'b0, 1'b0);
    exp_fetch(32'h8, 32'd2, 1, 1, 2, 0, 3, 8);
    serve(ILw, 2, 1, 32'h8, 1'b0, 1'b0);
    exp_fetch(32'hC, 32'd3, 0, 1, 2, 2, 3, 8);
    serve(ISw, 2, 1, 32'hC, 1'b0, 1'b0);
    exp_fetch(32'h40, 32'd4, 0, 1, 0, 0, 2, 5);
    serve(IBeq, 1, 0, 32'h40, 1'b0, 1'b1);
    exp_stop(3'd5, 2'd0, 32'h40, 32'd4, IEbrk, 0, 0, 1, 2);
    serve(IEbrk, 0, 0, 32'h44, 1'b0, 1'b0);
    wait_stop(20);
    idle_check(3'd5);

    // Fetch never answered: timeout trap after 15 request cycles.
    do_reset(1'b1);
    exp_start();
    release_rst();
    exp_stop(3'd6, 2'd1, 32'h0, 32'd0, 32'h0, 0, 0, 15, 15);
    serve(IAddi, -1, 0, 32'h4, 1'b0, 1'b0);
    wait_stop(40);
    idle_check(3'd6);

    // Valid and error together: error wins.
    do_reset(1'b1);
    exp_start();
    release_rst();
    exp_stop(3'd6, 2'd1, 32'h0, 32'd0, 32'h0, 0, 0, 2, 2);
    serve(IAddi, 1, 0, 32'h4, 1'b1, 1'b0);
    wait_stop(20);
    idle_check(3'd6);

    // Illegal all-zero opcode.
    do_reset(1'b1);
    exp_start();
    release_rst();
    exp_stop(3'd6, 2'd3, 32'h0, 32'd0, IZero, 0, 0, 1, 2);
    serve(IZero, 0, 0, 32'h4, 1'b0, 1'b0);
    wait_stop(20);
    idle_check(3'd6);

    // JALR to a misaligned target after one retired ADDI.
    do_reset(1'b1);
    exp_start();
    release_rst();
    exp_fetch(32'h4, 32'd1, 1, 1, 0, 0, 1, 4);
    serve(IAddi, 0, 0, 32'h4, 1'b0, 1'b0);
    exp_stop(3'd6, 2'd3, 32'h4, 32'd1, IJalr, -1, 1, 1, 4);
    serve(IJalr, 0, 0, 32'h102, 1'b0, 1'b0);
    wait_stop(20);
    idle_check(3'd6);

    // Reset asserted in the middle of a data access, then a clean restart.
    do_reset(1'b1);
    exp_start();
    release_rst();
    exp_fetch(32'h4, 32'd1, 1, 1, 0, 0, 1, 4);
    serve(IAddi, 0, 0, 32'h4, 1'b0, 1'b0);
    serve(ILw, 0, -1, 32'h8, 1'b0, 1'b0);
    chk("mid_mem_dmem_req", {31'd0, dmem_req_o}, 32'd1);
    do_reset(1'b0);
    exp_start();
    release_rst();
    exp_fetch(32'h4, 32'd1, 1, 1, 0, 0, 1, 4);
    serve(IAddi, 0, 0, 32'h4, 1'b0, 1'b0);
    n = 0;
    while (exp_q.size() != 0 && n < 20) begin
      @(negedge clk_i);
      n++;
    end
    chk("final_queue_drained", exp_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
